// File: rtl/rr_merge_arbiter_pkg.sv
// Shared router constants: packet field layout, default widths/depths and a
// constant-safe clog2 helper used for register sizing.
package rr_merge_arbiter_pkg;

  localparam int PKT_WIDTH = 30;
  localparam int DX_MSB    = 29;
  localparam int DX_LSB    = 21;
  localparam int DY_MSB    = 20;
  localparam int DY_LSB    = 12;

  // North/south packets carry no dx field.
  localparam int DEF_DATA_WIDTH = PKT_WIDTH - (DX_MSB - DX_LSB + 1);
  localparam int DEF_OUT_DEPTH  = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority search: first set request at or after start_i, wrapping,
// found by scanning the low half of a doubled and right-shifted request vector.
module rr_pick
  import rr_merge_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [2*N-1:0] dbl;

  always_comb begin
    int pos;
    pos   = 0;
    dbl   = {req_i, req_i} >> start_i;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && dbl[k]) begin
        any_o = 1'b1;
        pos   = int'(start_i) + k;
        if (pos >= N) pos = pos - N;
        idx_o = IW'(pos);
      end
    end
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/rr_merge_arbiter.sv
// Credit-based round-robin merge of NUM_IN FWFT source FIFOs into one
// downstream FIFO, with a per-source burst limit and registered write port.
module rr_merge_arbiter
  import rr_merge_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = rr_merge_arbiter_pkg::DEF_DATA_WIDTH,
  parameter int NUM_IN     = 3,
  parameter int OUT_DEPTH  = rr_merge_arbiter_pkg::DEF_OUT_DEPTH,
  parameter int MAX_BURST  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] din,
  input  logic [NUM_IN-1:0]            buffer_empty,
  output logic [NUM_IN-1:0]            read_en,
  input  logic                         out_ren,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         wen,
  output logic [clog2(NUM_IN)-1:0]     grant_idx,
  output logic                         credit_err
);

  localparam int IW = clog2(NUM_IN);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int CW = clog2(OUT_DEPTH + 1);

  localparam logic [IW-1:0] LAST_SRC   = IW'(NUM_IN - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(OUT_DEPTH);

  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wen_q, wen_d;
  logic                  err_q, err_d;

  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     start_idx;
  logic [IW-1:0]     sel;
  logic              pick_any;
  logic              hold;
  logic              issue;

  assign req       = ~buffer_empty;
  assign start_idx = (last_q == LAST_SRC) ? '0 : last_q + 1'b1;

  rr_pick #(
    .N  (NUM_IN),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .start_i (start_idx),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // burst_q is 0 only out of reset, so the first grant always searches from 0.
  assign hold  = req[last_q] && (burst_q != '0) && (burst_q < BURST_MAX);
  assign sel   = hold ? last_q : pick_idx;
  assign issue = reset_n && (credits_q != '0) && pick_any;

  assign read_en = !issue ? '0 :
                   hold   ? (NUM_IN'(1) << last_q) : pick_gnt;

  always_comb begin
    dout_d    = dout_q;
    wen_d     = 1'b0;
    last_d    = last_q;
    gidx_d    = gidx_q;
    burst_d   = burst_q;
    credits_d = credits_q;
    err_d     = err_q;

    if (issue) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == IW'(i)) dout_d = din[i*DATA_WIDTH +: DATA_WIDTH];
      end
      wen_d  = 1'b1;
      last_d = sel;
      gidx_d = sel;
      if (sel != last_q)             burst_d = BW'(1);
      else if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
    end

    if (issue && !out_ren) begin
      credits_d = credits_q - 1'b1;
    end else if (!issue && out_ren) begin
      if (credits_q == CREDIT_MAX) err_d = 1'b1;
      else                         credits_d = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q    <= '0;
      wen_q     <= 1'b0;
      last_q    <= LAST_SRC;
      gidx_q    <= '0;
      burst_q   <= '0;
      credits_q <= CREDIT_MAX;
      err_q     <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      wen_q     <= wen_d;
      last_q    <= last_d;
      gidx_q    <= gidx_d;
      burst_q   <= burst_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign dout       = dout_q;
  assign wen        = wen_q;
  assign grant_idx  = gidx_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Directed bench for rr_merge_arbiter: source FIFOs and downstream buffer are
// modelled here; expected writes are queued by hand and checked by a monitor.
module tb_rr_merge_arbiter;

  localparam int DW = 21;
  localparam int N  = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N*DW-1:0] din;
  logic [N-1:0]  buffer_empty;
  logic [N-1:0]  read_en;
  logic          out_ren;
  logic [DW-1:0] dout;
  logic          wen;
  logic [IW-1:0] grant_idx;
  logic          credit_err;

  typedef struct packed {
    logic [IW-1:0] g;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] src_q[N][$];

  int checks  = 0;
  int errors  = 0;
  int pops    = 0;
  int ds_cnt  = 0;
  int run     = 0;
  int max_run = 0;
  logic drain   = 1'b0;
  logic man_ren = 1'b0;
  logic [N-1:0] re_s;

  always #5 clk = ~clk;

  rr_merge_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din          (din),
    .buffer_empty (buffer_empty),
    .read_en      (read_en),
    .out_ren      (out_ren),
    .dout         (dout),
    .wen          (wen),
    .grant_idx    (grant_idx),
    .credit_err   (credit_err)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      buffer_empty[i]  = (src_q[i].size() == 0);
      din[i*DW +: DW]  = buffer_empty[i] ? '0 : src_q[i][0];
    end
    out_ren = drain ? (ds_cnt > 0) : man_ren;
  endfunction

  task automatic load(int s, logic [DW-1:0] base, int n);
    for (int k = 0; k < n; k++) src_q[s].push_back(base + DW'(k));
  endtask

  task automatic expect_w(int g, logic [DW-1:0] base, int n);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_t'{g: IW'(g), d: base + DW'(k)});
  endtask

  // Inputs change 1 time unit after the rising edge; read_en is sampled on the
  // falling edge, when it is settled for the coming rising edge.
  task automatic step();
    @(negedge clk);
    re_s = read_en;
    chk("read_en_onehot0", 64'($onehot0(re_s)), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (re_s[i]) begin
        if (src_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_of_empty: source %0d popped while empty", i);
        end else begin
          void'(src_q[i].pop_front());
          pops++;
        end
      end
    end
    ds_cnt = ds_cnt + (wen ? 1 : 0) - (out_ren ? 1 : 0);
    if (ds_cnt < 0) ds_cnt = 0;
    drive();
  endtask

  task automatic finish_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    drain   = 1'b0;
    man_ren = 1'b0;
    ds_cnt  = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("expected_drained", 64'(exp_q.size()), 0);
    #2;
    reset_n = 1'b0;
    finish_reset();
  endtask

  always @(negedge clk) begin
    if (reset_n && wen) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: dout=%0h grant=%0d expected no write", dout, grant_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dout", 64'(dout), 64'(e.d));
        chk("grant_idx", 64'(grant_idx), 64'(e.g));
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 64'(wen), 0);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_grant_idx", 64'(grant_idx), 0);
    chk("rst_credit_err", 64'(credit_err), 0);
    chk("rst_read_en", 64'(read_en), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Three sources, two words each: 0,0,1,1,2,2 back to back.
    load(0, 21'h0A000, 2);
    load(1, 21'h0B000, 2);
    load(2, 21'h0C000, 2);
    drain = 1'b1;
    drive();
    expect_w(0, 21'h0A000, 2);
    expect_w(1, 21'h0B000, 2);
    expect_w(2, 21'h0C000, 2);
    pops = 0; max_run = 0;
    repeat (6) step();
    chk("t1_pops", 64'(pops), 6);
    repeat (4) step();
    chk("t1_wen_run", 64'(max_run), 6);

    // Lone source is never throttled by the burst limit.
    do_reset();
    load(1, 21'h0D000, 6);
    drain = 1'b1;
    drive();
    expect_w(1, 21'h0D000, 6);
    pops = 0; max_run = 0;
    repeat (6) step();
    chk("t2_pops", 64'(pops), 6);
    repeat (4) step();
    chk("t2_wen_run", 64'(max_run), 6);
    chk("t2_no_err", 64'(credit_err), 0);

    // Credit exhaustion, then a single returned credit.
    do_reset();
    load(0, 21'h0E000, 3);
    load(1, 21'h0F000, 3);
    load(2, 21'h10000, 3);
    drive();
    expect_w(0, 21'h0E000, 2);
    expect_w(1, 21'h0F000, 2);
    expect_w(2, 21'h10000, 1);
    pops = 0;
    repeat (8) step();
    chk("t3_pops", 64'(pops), 4);
    man_ren = 1'b1;
    drive();
    step();
    chk("t4_no_pop_at_zero_credit", 64'(re_s), 0);
    man_ren = 1'b0;
    drive();
    step();
    chk("t4_pop_next_cycle", 64'(re_s), 64'h4);
    repeat (4) step();
    chk("t4_total_pops", 64'(pops), 5);

    // Credit return with full credits is an error and does not over-count.
    do_reset();
    chk("t5_err_before", 64'(credit_err), 0);
    man_ren = 1'b1;
    drive();
    step();
    man_ren = 1'b0;
    drive();
    step();
    chk("t5_err_set", 64'(credit_err), 1);
    load(0, 21'h11000, 5);
    drive();
    expect_w(0, 21'h11000, 4);
    pops = 0;
    repeat (8) step();
    chk("t5_pops", 64'(pops), 4);
    chk("t5_err_sticky", 64'(credit_err), 1);

    // Asynchronous reset while a write is pending.
    do_reset();
    chk("t5_err_cleared", 64'(credit_err), 0);
    load(0, 21'h12000, 4);
    drive();
    expect_w(0, 21'h12000, 2);
    pops = 0;
    repeat (3) step();
    chk("t6_wen_before_reset", 64'(wen), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_wen_in_reset", 64'(wen), 0);
    chk("t6_read_en_in_reset", 64'(read_en), 0);
    chk("t6_dout_in_reset", 64'(dout), 0);
    finish_reset();
    load(0, 21'h13000, 3);
    load(1, 21'h14000, 3);
    load(2, 21'h15000, 3);
    drive();
    expect_w(0, 21'h13000, 2);
    expect_w(1, 21'h14000, 2);
    pops = 0;
    repeat (8) step();
    chk("t6_pops_after_reset", 64'(pops), 4);

    repeat (2) step();
    chk("final_expected_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
